// File: rtl/module_bcd_pkg.sv
// Shared types for the BCD conversion controller: FSM states, requester ids,
// and the elaboration-time range check for the BCD result width.
package module_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic {
    ID_REQ_1 = 1'b0,
    ID_REQ_2 = 1'b1
  } req_id_t;

  // True when digits decimal digits can represent every width_in-bit value.
  function automatic bit bcd_range_ok(int unsigned digits, int unsigned width_in);
    longint unsigned pow10 = 1;
    longint unsigned max_bin;
    if (width_in == 0 || width_in >= 63) return 1'b0;
    max_bin = (64'd1 << width_in) - 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      if (pow10 > max_bin) return 1'b1;
      pow10 = pow10 * 64'd10;
    end
    return pow10 > max_bin;
  endfunction

endpackage

// File: rtl/module_bcd_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift the
// whole {bcd, binary} register left by one.
module module_bcd_step #(
  parameter int unsigned WIDTH_IN  = 8,
  parameter int unsigned WIDTH_OUT = 12
) (
  input  logic [WIDTH_OUT+WIDTH_IN-1:0] sr_in,
  output logic [WIDTH_OUT+WIDTH_IN-1:0] sr_out
);

  localparam int unsigned SW     = WIDTH_OUT + WIDTH_IN;
  localparam int unsigned DIGITS = WIDTH_OUT / 4;

  logic [SW-1:0] adj;

  always_comb begin
    adj = sr_in;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (adj[WIDTH_IN + 4*d +: 4] >= 4'd5)
        adj[WIDTH_IN + 4*d +: 4] = adj[WIDTH_IN + 4*d +: 4] + 4'd3;
    end
    sr_out = {adj[SW-2:0], 1'b0};
  end

endmodule

// File: rtl/module_bcd_conv_ctrl.sv
// Two-requester binary-to-BCD conversion controller (double dabble, one bit per cycle).
// Define BCD_CTRL_RR_ARB_EN for round-robin arbitration; default is fixed priority to requester 1.
module module_bcd_conv_ctrl
  import module_bcd_pkg::*;
#(
  parameter int unsigned WIDTH_IN  = 8,
  parameter int unsigned WIDTH_OUT = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_1,
  input  logic                 req_2,
  input  logic [WIDTH_IN-1:0]  bin_1,
  input  logic [WIDTH_IN-1:0]  bin_2,
  output logic                 ack_1,
  output logic                 ack_2,
  output logic [WIDTH_OUT-1:0] bcd,
  output logic                 out_id,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int unsigned SW = WIDTH_OUT + WIDTH_IN;
  localparam int unsigned CW = (WIDTH_IN < 2) ? 1 : $clog2(WIDTH_IN + 1);

  generate
    if ((WIDTH_OUT % 4) != 0 || !bcd_range_ok(WIDTH_OUT / 4, WIDTH_IN)) begin : g_param_err
      $error("module_bcd_conv_ctrl: WIDTH_OUT must be a multiple of 4 and hold every WIDTH_IN-bit value");
    end
  endgenerate

  state_t        state_q, state_d;
  req_id_t       sel, id_q;
  logic [SW-1:0] sr_q, sr_step;
  logic [CW-1:0] cnt_q;
`ifdef BCD_CTRL_RR_ARB_EN
  req_id_t       last_q;
`endif

  module_bcd_step #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT)
  ) u_step (
    .sr_in  (sr_q),
    .sr_out (sr_step)
  );

  always_comb begin
    state_d = state_q;
    ack_1   = 1'b0;
    ack_2   = 1'b0;
`ifdef BCD_CTRL_RR_ARB_EN
    // On a tie, grant whoever was not granted last; reset value favours requester 1.
    if (req_1 && req_2) sel = (last_q == ID_REQ_1) ? ID_REQ_2 : ID_REQ_1;
    else                sel = req_1 ? ID_REQ_1 : ID_REQ_2;
`else
    sel = req_1 ? ID_REQ_1 : ID_REQ_2;
`endif
    case (state_q)
      IDLE: begin
        if (!rst) begin
          ack_1 = req_1 && (sel == ID_REQ_1);
          ack_2 = req_2 && (sel == ID_REQ_2);
          if (ack_1 || ack_2) state_d = SHIFT;
        end
      end
      SHIFT:   if (cnt_q == CW'(WIDTH_IN - 1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      id_q    <= ID_REQ_1;
`ifdef BCD_CTRL_RR_ARB_EN
      last_q  <= ID_REQ_2;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (ack_1 || ack_2)) begin
        sr_q   <= {{WIDTH_OUT{1'b0}}, (ack_1 ? bin_1 : bin_2)};
        id_q   <= ack_1 ? ID_REQ_1 : ID_REQ_2;
        cnt_q  <= '0;
`ifdef BCD_CTRL_RR_ARB_EN
        last_q <= ack_1 ? ID_REQ_1 : ID_REQ_2;
`endif
      end else if (state_q == SHIFT) begin
        sr_q  <= sr_step;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign bcd       = sr_q[SW-1 -: WIDTH_OUT];
  assign out_id    = id_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_module_bcd_conv_ctrl.sv
// Directed self-checking bench for module_bcd_conv_ctrl (8-bit in, 3 BCD digits out).
module tb_module_bcd_conv_ctrl;

  logic        clk = 1'b0;
  logic        rst, req_1, req_2, out_ready;
  logic [7:0]  bin_1, bin_2;
  logic        ack_1, ack_2, out_id, out_valid, busy;
  logic [11:0] bcd;

  int checks = 0;
  int errors = 0;

  module_bcd_conv_ctrl #(
    .WIDTH_IN  (8),
    .WIDTH_OUT (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_1     (req_1),
    .req_2     (req_2),
    .bin_1     (bin_1),
    .bin_2     (bin_2),
    .ack_1     (ack_1),
    .ack_2     (ack_2),
    .bcd       (bcd),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input logic [7:0] v);
    int unsigned n;
    n = v;
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat = i;
    end
  endtask

  // Full conversion with out_ready already high: ack, latency, result, id, return to idle.
  task automatic convert(input bit who, input logic [7:0] v, input logic [11:0] exp, input string tag);
    int lat;
    @(negedge clk);
    if (!who) begin req_1 = 1'b1; bin_1 = v; end
    else      begin req_2 = 1'b1; bin_2 = v; end
    #1;
    checks++;
    if ((who ? ack_2 : ack_1) !== 1'b1) begin
      errors++; $display("FAIL %s_ack: got %b want 1", tag, who ? ack_2 : ack_1);
    end
    @(posedge clk); #1;
    checks++;
    if ({ack_1, ack_2} !== 2'b00) begin
      errors++; $display("FAIL %s_ack_one_edge: got %b want 00", tag, {ack_1, ack_2});
    end
    req_1 = 1'b0; req_2 = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat != 8) begin errors++; $display("FAIL %s_latency: got %0d want 8", tag, lat); end
    checks++;
    if (bcd !== exp) begin errors++; $display("FAIL %s_bcd: got %h want %h", tag, bcd, exp); end
    checks++;
    if (out_id !== who) begin errors++; $display("FAIL %s_id: got %b want %b", tag, out_id, who); end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL %s_release: valid/busy got %b want 00", tag, {out_valid, busy});
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; req_1 = 1'b1; bin_1 = 8'd7;
    #1;
    checks++;
    if ({ack_1, ack_2} !== 2'b00) begin
      errors++; $display("FAIL reset_ack: got %b want 00", {ack_1, ack_2});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, out_valid, out_id, bcd} !== 15'd0) begin
      errors++; $display("FAIL reset_state: busy/valid/id/bcd got %b%b%b %h want all 0",
                         busy, out_valid, out_id, bcd);
    end
    @(negedge clk);
    rst = 1'b0; req_1 = 1'b0;
  endtask

  task automatic test_values;
    convert(1'b0, 8'd255, 12'h255, "max");
    convert(1'b0, 8'd0,   12'h000, "zero");
    convert(1'b0, 8'd99,  12'h099, "ninety_nine");
    convert(1'b1, 8'd100, 12'h100, "hundred_req2");
  endtask

  task automatic test_sweep;
    for (int v = 0; v < 256; v++)
      convert(v[0], 8'(v), ref_bcd(8'(v)), "sweep");
  endtask

  task automatic test_arbitration;
    int  lat;
    logic [1:0]  exp_ack2;
    logic [11:0] exp_bcd2;
`ifdef BCD_CTRL_RR_ARB_EN
    exp_ack2 = 2'b01; exp_bcd2 = 12'h020;
`else
    exp_ack2 = 2'b10; exp_bcd2 = 12'h010;
`endif
    @(negedge clk);
    req_1 = 1'b1; req_2 = 1'b1; bin_1 = 8'd10; bin_2 = 8'd20;
    #1;
    checks++;
    if ({ack_1, ack_2} !== 2'b10) begin
      errors++; $display("FAIL arb_first_ack: got %b want 10", {ack_1, ack_2});
    end
    @(posedge clk);
    wait_valid(lat);
    checks++;
    if ({out_id, bcd} !== {1'b0, 12'h010}) begin
      errors++; $display("FAIL arb_first_result: id/bcd got %b/%h want 0/010", out_id, bcd);
    end
    @(posedge clk); #1;
    checks++;
    if ({ack_1, ack_2} !== exp_ack2) begin
      errors++; $display("FAIL arb_second_ack: got %b want %b", {ack_1, ack_2}, exp_ack2);
    end
    @(posedge clk); #1;
    req_1 = 1'b0; req_2 = 1'b0;
    wait_valid(lat);
    checks++;
    if ({out_id, bcd} !== {exp_ack2[0], exp_bcd2}) begin
      errors++; $display("FAIL arb_second_result: id/bcd got %b/%h want %b/%h",
                         out_id, bcd, exp_ack2[0], exp_bcd2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    @(negedge clk);
    req_2 = 1'b1; bin_2 = 8'd77; bin_1 = 8'd5;
    @(posedge clk); #1;
    req_2 = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat != 8 || bcd !== 12'h077 || out_id !== 1'b1) begin
      errors++; $display("FAIL bp_result: lat/bcd/id got %0d/%h/%b want 8/077/1", lat, bcd, out_id);
    end
    req_1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bcd !== 12'h077 || out_id !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b1 ||
          {ack_1, ack_2} !== 2'b00) begin
        errors++; $display("FAIL bp_hold: bcd/id/busy/valid/acks got %h/%b/%b/%b/%b want 077/1/1/1/00",
                           bcd, out_id, busy, out_valid, {ack_1, ack_2});
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, busy, ack_1} !== 3'b001) begin
      errors++; $display("FAIL bp_release: valid/busy/ack_1 got %b want 001", {out_valid, busy, ack_1});
    end
    @(posedge clk); #1;
    req_1 = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat != 8 || bcd !== 12'h005 || out_id !== 1'b0) begin
      errors++; $display("FAIL back_to_back: lat/bcd/id got %0d/%h/%b want 8/005/0", lat, bcd, out_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift;
    int seen;
    @(negedge clk);
    req_1 = 1'b1; bin_1 = 8'd200;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, out_valid, ack_1, ack_2} !== 4'b0000) begin
      errors++; $display("FAIL midreset_state: busy/valid/acks got %b want 0000",
                         {busy, out_valid, ack_1, ack_2});
    end
    @(negedge clk);
    rst = 1'b0; req_1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_no_result: got %0d active cycles want 0", seen); end
    convert(1'b0, 8'd42, 12'h042, "after_reset");
  endtask

  initial begin
    rst = 1'b1; req_1 = 1'b0; req_2 = 1'b0; out_ready = 1'b1;
    bin_1 = '0; bin_2 = '0;
    test_reset();
    test_values();
    test_arbitration();
    test_backpressure();
    test_reset_mid_shift();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
